// File: rtl/avalon_pio_pkg.sv
// Shared constants and enums for the Avalon-MM PIO/HEX responder.
package avalon_pio_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [ADDR_W-1:0] {
    REG_DATA_OUT = 3'd0,
    REG_DATA_IN  = 3'd1,
    REG_IRQ_MASK = 3'd2,
    REG_EDGE_CAP = 3'd3,
    REG_HEX      = 3'd4
  } reg_idx_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/avalon_pio_responder_if.sv
// Avalon-MM slave-side bus bundle for the PIO responder.
interface avalon_pio_responder_if;
  import avalon_pio_pkg::*;

  logic [ADDR_W-1:0] avs_address;
  logic              avs_byteenable;
  logic              avs_read;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic              avs_waitrequest;
  logic              avs_readdatavalid;

  modport master (
    output avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest, avs_readdatavalid
  );

endinterface

// File: rtl/avalon_read_pipe.sv
// Fixed-latency valid/data delay line; the last data stage holds its value
// between valid beats. Async reset clears everything, flush drops in-flight beats.
module avalon_read_pipe #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned WIDTH   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;
  logic [WIDTH-1:0]   data_q [LATENCY];
  logic [WIDTH-1:0]   data_d [LATENCY];

  assign valid_d[0] = in_valid & ~flush;
  assign data_d[0]  = in_valid ? in_data : data_q[0];

  // Data only moves with its valid so every stage keeps the last real beat.
  for (genvar i = 1; i < LATENCY; i++) begin : g_stage
    assign valid_d[i] = valid_q[i-1] & ~flush;
    assign data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/avalon_pio_responder.sv
// Byte-wide Avalon-MM PIO/HEX responder with wait-states and fixed read latency.
// Optional AVALON_PIO_IRQ_EN builds IRQ_MASK, EDGE_CAP and the level irq.
module avalon_pio_responder
  import avalon_pio_pkg::*;
#(
  parameter int unsigned       WAIT_STATES  = 1,
  parameter int unsigned       READ_LATENCY = 2,
  parameter logic [DATA_W-1:0] OUT_RESET    = 8'h00
) (
  input  logic                   clock,
  input  logic                   reset,
  avalon_pio_responder_if.slave  avs,
  input  logic [DATA_W-1:0]      pio_in,
  output logic [DATA_W-1:0]      pio_out,
  output logic [DATA_W-1:0]      hex_out,
  output logic                   irq
);

  state_e            state;
  state_e            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              req;
  logic              waitreq;
  logic              accept;
  logic              wr_en;
  logic              rd_accept;
  reg_idx_e          addr;
  logic [DATA_W-1:0] sync1;
  logic [DATA_W-1:0] sync2;
  logic [DATA_W-1:0] rd_mux;

  assign req  = avs.avs_read | avs.avs_write;
  assign addr = reg_idx_e'(avs.avs_address);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Wait-state sequencer; a request that vanishes mid-wait is dropped silently.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    waitreq   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            accept = 1'b1;
          end else begin
            waitreq   = 1'b1;
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(WAIT_STATES)) begin
          accept    = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          waitreq = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign avs.avs_waitrequest = waitreq;

  // A simultaneous read and write is serviced as a write only.
  assign wr_en     = accept & avs.avs_write & avs.avs_byteenable;
  assign rd_accept = accept & avs.avs_read & ~avs.avs_write;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pio_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pio_out <= OUT_RESET;
      hex_out <= OUT_RESET;
    end else if (wr_en) begin
      case (addr)
        REG_DATA_OUT: pio_out <= avs.avs_writedata;
        REG_HEX:      hex_out <= avs.avs_writedata;
        default:      ;
      endcase
    end
  end

`ifdef AVALON_PIO_IRQ_EN
  logic [DATA_W-1:0] sync3;
  logic [DATA_W-1:0] irq_mask;
  logic [DATA_W-1:0] edge_cap;
  logic [DATA_W-1:0] cap_clr;
  logic [DATA_W-1:0] cap_set;

  assign cap_clr = (wr_en && addr == REG_EDGE_CAP) ? avs.avs_writedata : '0;
  assign cap_set = sync2 & ~sync3;

  // Set has priority over write-1-to-clear on the same bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync3    <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      sync3    <= sync2;
      edge_cap <= (edge_cap & ~cap_clr) | cap_set;
      irq      <= |(edge_cap & irq_mask);
      if (wr_en && addr == REG_IRQ_MASK) begin
        irq_mask <= avs.avs_writedata;
      end
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_DATA_OUT: rd_mux = pio_out;
      REG_DATA_IN:  rd_mux = sync2;
`ifdef AVALON_PIO_IRQ_EN
      REG_IRQ_MASK: rd_mux = irq_mask;
      REG_EDGE_CAP: rd_mux = edge_cap;
`endif
      REG_HEX:      rd_mux = hex_out;
      default:      rd_mux = '0;
    endcase
  end

  avalon_read_pipe #(
    .LATENCY (READ_LATENCY),
    .WIDTH   (DATA_W)
  ) u_read_pipe (
    .clock     (clock),
    .reset     (reset),
    .flush     (1'b0),
    .in_valid  (rd_accept),
    .in_data   (rd_mux),
    .out_valid (avs.avs_readdatavalid),
    .out_data  (avs.avs_readdata)
  );

endmodule

// File: tb/tb_avalon_pio_responder.sv
// Directed bench: dut_a has two wait-states, dut_b none; both share clock, reset and pio_in.
module tb_avalon_pio_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] pio_in;
  logic [7:0] pio_out_a, hex_a, pio_out_b, hex_b;
  logic       irq_a, irq_b;
  int         n_checks = 0;
  int         n_fail   = 0;

  avalon_pio_responder_if ifa ();
  avalon_pio_responder_if ifb ();

  always #5 clock = ~clock;

  avalon_pio_responder #(
    .WAIT_STATES (2),
    .READ_LATENCY(2),
    .OUT_RESET   (8'h00)
  ) dut_a (
    .clock  (clock),
    .reset  (reset),
    .avs    (ifa),
    .pio_in (pio_in),
    .pio_out(pio_out_a),
    .hex_out(hex_a),
    .irq    (irq_a)
  );

  avalon_pio_responder #(
    .WAIT_STATES (0),
    .READ_LATENCY(2),
    .OUT_RESET   (8'h5A)
  ) dut_b (
    .clock  (clock),
    .reset  (reset),
    .avs    (ifb),
    .pio_in (pio_in),
    .pio_out(pio_out_b),
    .hex_out(hex_b),
    .irq    (irq_b)
  );

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_a();
    ifa.avs_address = 3'd0; ifa.avs_byteenable = 1'b0; ifa.avs_read = 1'b0;
    ifa.avs_write = 1'b0; ifa.avs_writedata = 8'h00;
  endtask

  task automatic idle_b();
    ifb.avs_address = 3'd0; ifb.avs_byteenable = 1'b0; ifb.avs_read = 1'b0;
    ifb.avs_write = 1'b0; ifb.avs_writedata = 8'h00;
  endtask

  task automatic write_b(input logic [2:0] a, input logic [7:0] d);
    ifb.avs_address = a; ifb.avs_writedata = d; ifb.avs_byteenable = 1'b1; ifb.avs_write = 1'b1;
    step();
    idle_b();
  endtask

  task automatic read_b(input string tag, input logic [2:0] a, input logic [7:0] exp);
    ifb.avs_address = a; ifb.avs_read = 1'b1;
    step();
    idle_b();
    chk1({tag, "_rdv_early"}, ifb.avs_readdatavalid, 1'b0);
    step();
    chk1({tag, "_rdv"}, ifb.avs_readdatavalid, 1'b1);
    chk8({tag, "_data"}, ifb.avs_readdata, exp);
  endtask

  initial begin
    reset = 1'b1;
    pio_in = 8'h00;
    idle_a();
    idle_b();
    #3;
    chk8("rst_pio_out_a", pio_out_a, 8'h00);
    chk8("rst_pio_out_b", pio_out_b, 8'h5A);
    chk8("rst_hex_b", hex_b, 8'h5A);
    chk1("rst_irq_b", irq_b, 1'b0);
    chk1("rst_rdv_a", ifa.avs_readdatavalid, 1'b0);
    chk8("rst_rdata_a", ifa.avs_readdata, 8'h00);
    chk1("rst_wait_a_noreq", ifa.avs_waitrequest, 1'b0);
    step();
    reset = 1'b0;
    step();
    step();

    // Two wait-states then a write to DATA_OUT.
    ifa.avs_address = 3'd0; ifa.avs_writedata = 8'hA5; ifa.avs_byteenable = 1'b1; ifa.avs_write = 1'b1;
    #1;
    chk1("wr_a_wait_c1", ifa.avs_waitrequest, 1'b1);
    step();
    chk1("wr_a_wait_c2", ifa.avs_waitrequest, 1'b1);
    chk8("wr_a_pio_before", pio_out_a, 8'h00);
    step();
    chk1("wr_a_wait_c3", ifa.avs_waitrequest, 1'b0);
    step();
    idle_a();
    chk8("wr_a_pio_after", pio_out_a, 8'hA5);
    chk1("wr_a_no_rdv0", ifa.avs_readdatavalid, 1'b0);
    step();
    chk1("wr_a_no_rdv1", ifa.avs_readdatavalid, 1'b0);
    step();
    chk1("wr_a_no_rdv2", ifa.avs_readdatavalid, 1'b0);

    // DATA_IN read through wait-states and a 2-cycle read pipe.
    pio_in = 8'h3C;
    step(); step(); step();
    ifa.avs_address = 3'd1; ifa.avs_read = 1'b1;
    #1;
    chk1("rd_a_wait_c1", ifa.avs_waitrequest, 1'b1);
    step();
    chk1("rd_a_wait_c2", ifa.avs_waitrequest, 1'b1);
    step();
    chk1("rd_a_wait_c3", ifa.avs_waitrequest, 1'b0);
    step();
    idle_a();
    chk1("rd_a_rdv_lat1", ifa.avs_readdatavalid, 1'b0);
    step();
    chk1("rd_a_rdv_lat2", ifa.avs_readdatavalid, 1'b1);
    chk8("rd_a_data", ifa.avs_readdata, 8'h3C);
    step();
    chk1("rd_a_rdv_drop", ifa.avs_readdatavalid, 1'b0);
    chk8("rd_a_data_hold", ifa.avs_readdata, 8'h3C);

    // Zero wait-states: HEX write, then back-to-back reads 0,1,4,0.
    ifb.avs_address = 3'd4; ifb.avs_writedata = 8'hC3; ifb.avs_byteenable = 1'b1; ifb.avs_write = 1'b1;
    #1;
    chk1("wr_b_nowait", ifb.avs_waitrequest, 1'b0);
    step();
    idle_b();
    chk8("wr_b_hex", hex_b, 8'hC3);
    ifb.avs_address = 3'd0; ifb.avs_read = 1'b1;
    #1;
    chk1("b2b_nowait", ifb.avs_waitrequest, 1'b0);
    step();
    chk1("b2b_rdv_e0", ifb.avs_readdatavalid, 1'b0);
    ifb.avs_address = 3'd1;
    step();
    chk1("b2b_rdv_1", ifb.avs_readdatavalid, 1'b1);
    chk8("b2b_data_1", ifb.avs_readdata, 8'h5A);
    ifb.avs_address = 3'd4;
    step();
    chk1("b2b_rdv_2", ifb.avs_readdatavalid, 1'b1);
    chk8("b2b_data_2", ifb.avs_readdata, 8'h3C);
    ifb.avs_address = 3'd0;
    step();
    chk1("b2b_rdv_3", ifb.avs_readdatavalid, 1'b1);
    chk8("b2b_data_3", ifb.avs_readdata, 8'hC3);
    idle_b();
    step();
    chk1("b2b_rdv_4", ifb.avs_readdatavalid, 1'b1);
    chk8("b2b_data_4", ifb.avs_readdata, 8'h5A);
    step();
    chk1("b2b_rdv_end", ifb.avs_readdatavalid, 1'b0);

    // Unmapped index reads 0; byteenable=0 write is a no-op; read+write acts as write.
    read_b("rd_b_idx5", 3'd5, 8'h00);
    ifb.avs_address = 3'd0; ifb.avs_writedata = 8'hFF; ifb.avs_byteenable = 1'b0; ifb.avs_write = 1'b1;
    step();
    idle_b();
    chk8("be0_pio_b", pio_out_b, 8'h5A);
    ifb.avs_address = 3'd0; ifb.avs_writedata = 8'h11; ifb.avs_byteenable = 1'b1;
    ifb.avs_write = 1'b1; ifb.avs_read = 1'b1;
    step();
    idle_b();
    chk8("rw_pio_b", pio_out_b, 8'h11);
    step();
    chk1("rw_no_rdv1", ifb.avs_readdatavalid, 1'b0);
    step();
    chk1("rw_no_rdv2", ifb.avs_readdatavalid, 1'b0);

`ifdef AVALON_PIO_IRQ_EN
    // Clear edges left by pio_in=3C, unmask bit 0, then raise pio_in[0].
    write_b(3'd3, 8'hFF);
    write_b(3'd2, 8'h01);
    step();
    chk1("irq_idle", irq_b, 1'b0);
    pio_in = 8'h3D;
    step(); step(); step();
    chk1("irq_not_yet", irq_b, 1'b0);
    step();
    chk1("irq_set", irq_b, 1'b1);
    read_b("cap_rise", 3'd3, 8'h01);
    read_b("mask_rd", 3'd2, 8'h01);
    write_b(3'd3, 8'h01);
    chk1("irq_clr_lag", irq_b, 1'b1);
    step();
    chk1("irq_clr", irq_b, 1'b0);
    // Rising edge lands on the same edge as a clear: the set wins.
    pio_in = 8'h3C;
    step(); step(); step(); step();
    pio_in = 8'h3D;
    step(); step();
    write_b(3'd3, 8'h01);
    read_b("cap_set_wins", 3'd3, 8'h01);
    chk1("irq_set_wins", irq_b, 1'b1);
`else
    write_b(3'd2, 8'hFF);
    write_b(3'd3, 8'hFF);
    pio_in = 8'h3D; step(); step();
    pio_in = 8'h3C; step(); step();
    pio_in = 8'hFF; step(); step(); step(); step();
    chk1("noirq_b", irq_b, 1'b0);
    chk1("noirq_a", irq_a, 1'b0);
    read_b("noirq_idx2", 3'd2, 8'h00);
    read_b("noirq_idx3", 3'd3, 8'h00);
    read_b("noirq_datain", 3'd1, 8'hFF);
`endif

    // Reset lands one cycle after a read is accepted on dut_a.
    ifa.avs_address = 3'd0; ifa.avs_read = 1'b1;
    step(); step(); step();
    idle_a();
    #1;
    reset = 1'b1;
    #1;
    chk8("async_pio_a", pio_out_a, 8'h00);
    chk8("async_pio_b", pio_out_b, 8'h5A);
    chk8("async_hex_b", hex_b, 8'h5A);
    chk1("async_irq_b", irq_b, 1'b0);
    chk8("async_rdata_a", ifa.avs_readdata, 8'h00);
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk1("flushed_rdv_a", ifa.avs_readdatavalid, 1'b0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_pio_responder.md
Name: avalon_pio_responder

Overview:
- Byte-wide Avalon-MM responder that sits on the core's main data port as a memory-mapped PIO/HEX peripheral.
- Generates waitrequest wait-states and a fixed-latency readdatavalid, so the core's master-side stall handling runs against real hardware instead of mocks.
- Drives parallel output pins and a HEX register, and samples input pins.
- Produces a level interrupt from rising-edge capture on the inputs, suitable for the core's inr_irq.

Parameters:
- WAIT_STATES, 1, number of cycles waitrequest is held high per access before it is accepted (0..15).
- READ_LATENCY, 2, cycles from read acceptance to the readdatavalid pulse (1..8).
- OUT_RESET, 8'h00, reset value of pio_out and hex_out.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- avs_address  input  3  register index
- avs_byteenable  input  1  write lane enable
- avs_read  input  1  read request
- avs_readdata  output  8  read data
- avs_write  input  1  write request
- avs_writedata  input  8  write data
- avs_waitrequest  output  1  stall; master holds all request signals while high
- avs_readdatavalid  output  1  one-cycle pulse qualifying avs_readdata
- pio_in  input  8  asynchronous input pins
- pio_out  output  8  output register
- hex_out  output  8  HEX display register
- irq  output  1  registered interrupt request

Behaviour:
- Reset is asynchronous and active-high, applied to every flop:
  - pio_out and hex_out = OUT_RESET.
  - avs_readdata = 0, avs_readdatavalid = 0, irq = 0.
  - Synchroniser, edge-capture and mask registers = 0.
  - FSM returns to IDLE and the read pipe is flushed. A read accepted before reset never produces readdatavalid.
- Register map (index: access):
  - 0 DATA_OUT: RW
  - 1 DATA_IN: RO, 2-flop synchronised pio_in
  - 2 IRQ_MASK: RW
  - 3 EDGE_CAP: R, write-1-to-clear
  - 4 HEX: RW
  - 5-7: read 0, writes ignored
- FSM states and transitions:
  - IDLE: on (read|write), if WAIT_STATES=0 accept this cycle, else go to WAIT with cnt=1.
  - WAIT: waitrequest=1; cnt increments each cycle. When cnt==WAIT_STATES, waitrequest=0, accept, return to IDLE.
  - If read and write both drop during WAIT (protocol violation), return to IDLE with no side effects.
- Waitrequest timing:
  - avs_waitrequest is combinational from state, cnt and (read|write).
  - It is 0 when no request is present.
  - It is 1 on the first cycle of any request when WAIT_STATES>0.
- Accept = (read|write) && !waitrequest.
  - Writes take effect at the accepting clock edge.
  - byteenable=0 writes are still accepted and produce no register change.
  - Simultaneous read and write: treated as a write only; no readdatavalid.
- Reads:
  - Data is muxed at accept and shifted through a READ_LATENCY-stage pipe.
  - avs_readdatavalid is high exactly READ_LATENCY cycles after the accepting edge, for one cycle.
  - avs_readdata holds its last value otherwise.
- Back-to-back throughput: with WAIT_STATES=0, one access is accepted every cycle, and outstanding reads retire in order with no gaps or loss.
- Edge capture:
  - cap[i] is set on a rising edge of synchronised pio_in[i].
  - Writing 1 to cap[i] clears it.
  - If a set and a clear occur in the same cycle, the set wins.
- irq is registered: irq <= |(cap & mask). It asserts 1 cycle after the cap/mask update.
- DATA_IN reflects pio_in 2 cycles after the change, plus the read latency.

Optional Feature:
- Macro: AVALON_PIO_IRQ_EN.
- Defined: IRQ_MASK, EDGE_CAP and irq logic behave as described in Behaviour.
- Undefined:
  - The IRQ_MASK, EDGE_CAP and edge-detect flops are not built.
  - Indices 2 and 3 read 0 and writes to them are ignored.
  - irq is tied to 0.
  - Wait-state and latency behaviour is unchanged.

Decomposition:
- Package avalon_pio_pkg holds:
  - the register index enum (REG_DATA_OUT..REG_HEX)
  - the FSM state enum (IDLE, WAIT)
  - address width and data width constants
- Sub-module avalon_read_pipe: a READ_LATENCY-deep valid/data delay line with async reset and flush. It is reusable by other responders.

Test Plan:
- WAIT_STATES=2, READ_LATENCY=2, write 8'hA5 to index 0 -> waitrequest high for 2 cycles, accepted on cycle 3, pio_out=8'hA5 after that edge, no readdatavalid.
- pio_in=8'h3C held, then read index 1 -> readdatavalid exactly 2 cycles after accept, readdata=8'h3C.
- WAIT_STATES=0, four back-to-back reads of indices 0,1,4,0 -> four consecutive readdatavalid pulses carrying the matching values in order.
- Mask=8'h01, pio_in[0] rises 0->1 -> cap=8'h01 and irq=1 within 4 cycles; write 8'h01 to index 3 -> irq=0 next cycle; with a rising edge in the same cycle as the clear, cap stays 8'h01.
- Read accepted, reset asserted 1 cycle later -> readdatavalid never pulses; pio_out=OUT_RESET and irq=0 immediately, asynchronously.
- Build without AVALON_PIO_IRQ_EN, toggle pio_in and write 8'hFF to index 2 -> irq stays 0, reads of indices 2 and 3 return 8'h00.
